// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encodings and the
// load clamp used wherever a parallel-load value must stay inside the modulus.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns min(value, modulus-1) so a loaded value never leaves 0..modulus-1.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input int unsigned modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/tc_detect.sv
// Terminal-count detector: flags "at the limit in the current direction"
// (top value when counting up, zero when counting down). Not reset-gated,
// so cascade controllers can apply their own qualification.
module tc_detect
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MODULUS = 32
) (
    input  logic [WIDTH-1:0] s,
    input  logic             up,
    input  logic             en,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // Limit detection in the active direction, qualified by the enable.
    always_comb begin
        if (up == DIR_UP) tc = en && (s == MAX_VAL);
        else              tc = en && (s == '0);
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Synchronous up/down modulo counter with parallel load, count enable and
// cascade carry. Priority per edge: load > en > hold.
// Build option: define UPDOWN_COUNTER_SATURATE_EN to make the counter stop at
// its limits instead of wrapping (wrap is then never asserted).
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MODULUS = 32
) (
    input  logic             pulse,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] s,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] s_next;
    logic             wrap_next;
    logic [WIDTH:0]   s_inc;
    logic [WIDTH:0]   s_dec;
    logic             tc_raw;

    tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .s  (s),
        .up (up),
        .en (en),
        .tc (tc_raw)
    );

    // Terminal count is combinational so it can feed the next stage's en on
    // the same edge; forced low while reset is asserted.
    assign tc = reset && tc_raw;

    // One extra bit exposes overflow past MODULUS-1 and the borrow below zero.
    assign s_inc = {1'b0, s} + (WIDTH + 1)'(1);
    assign s_dec = {1'b0, s} - (WIDTH + 1)'(1);

    // Next-state mux: load, then count in the selected direction, else hold.
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        s_next    = s;
        wrap_next = 1'b0;
        if (load) begin
            s_next = WIDTH'(clamp_load(32'(load_val), MODULUS));
        end else if (en) begin
            if (up == DIR_UP) begin
                if (s_inc >= MOD_EXT) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    s_next    = MAX_VAL;
`else
                    s_next    = '0;
                    wrap_next = 1'b1;
`endif
                end else begin
                    s_next = s_inc[WIDTH-1:0];
                end
            end else begin
                if (s_dec[WIDTH]) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    s_next    = '0;
`else
                    s_next    = MAX_VAL;
                    wrap_next = 1'b1;
`endif
                end else begin
                    s_next = s_dec[WIDTH-1:0];
                end
            end
        end
    end

    // State register; asynchronous reset clears count and wrap immediately.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, keeping all bits updating on the same edge.
    always_ff @(posedge pulse or negedge reset) begin
        if (!reset) begin
            s    <= '0;
            wrap <= 1'b0;
        end else begin
            s    <= s_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod (WIDTH=4, MODULUS=10): directed
// scenarios, a randomized run against a behavioural model, asynchronous reset
// and a two-digit cascade.
module tb_updown_counter_mod;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         pulse;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] s;
    logic         tc;
    logic         wrap;

    logic         casc_en;
    logic [W-1:0] units_s, tens_s;
    logic         units_tc, tens_tc, units_wrap, tens_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state for the single instance
    int m_s    = 0;
    int m_wrap = 0;

    updown_counter_mod #(.WIDTH(W), .MODULUS(MOD)) u_dut (
        .pulse    (pulse),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .s        (s),
        .tc       (tc),
        .wrap     (wrap)
    );

    updown_counter_mod #(.WIDTH(W), .MODULUS(MOD)) u_units (
        .pulse    (pulse),
        .reset    (reset),
        .en       (casc_en),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .s        (units_s),
        .tc       (units_tc),
        .wrap     (units_wrap)
    );

    updown_counter_mod #(.WIDTH(W), .MODULUS(MOD)) u_tens (
        .pulse    (pulse),
        .reset    (reset),
        .en       (units_tc),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .s        (tens_s),
        .tc       (tens_tc),
        .wrap     (tens_wrap)
    );

    initial pulse = 1'b0;
    always #5 pulse = ~pulse;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Value after one enabled step in direction u.
    function automatic int step_val(input int v, input bit u);
`ifdef UPDOWN_COUNTER_SATURATE_EN
        if (u) return (v == MOD - 1) ? v : v + 1;
        else   return (v == 0) ? v : v - 1;
`else
        return u ? (v + 1) % MOD : (v + MOD - 1) % MOD;
`endif
    endfunction

    // Whether that step crosses the modulus boundary.
    function automatic int step_wraps(input int v, input bit u);
`ifdef UPDOWN_COUNTER_SATURATE_EN
        return 0;
`else
        return (u && v == MOD - 1) || (!u && v == 0) ? 1 : 0;
`endif
    endfunction

    function automatic int model_tc(input int v, input bit e, input bit u);
        return (reset && e && ((u && v == MOD - 1) || (!u && v == 0))) ? 1 : 0;
    endfunction

    // Drive one cycle of inputs, check tc before the edge and s/wrap after it.
    task automatic tick(input bit ld, input int lv, input bit e, input bit u, input string tag);
        load     = ld;
        load_val = W'(lv);
        en       = e;
        up       = u;
        #1;
        check({tag, " tc"}, 32'(tc), 32'(model_tc(m_s, e, u)));
        @(posedge pulse);
        #1;
        if (!reset) begin
            m_s    = 0;
            m_wrap = 0;
        end else if (ld) begin
            m_s    = (lv < MOD) ? lv : MOD - 1;
            m_wrap = 0;
        end else if (e) begin
            m_wrap = step_wraps(m_s, u);
            m_s    = step_val(m_s, u);
        end else begin
            m_wrap = 0;
        end
        check({tag, " s"}, 32'(s), 32'(m_s));
        check({tag, " wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    initial begin
        int cu, ct, tc_u, wu, wt, tens_wraps;

        reset    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        up       = 1'b0;
        casc_en  = 1'b0;

        // Reset held for 3 edges; down+en at 0 would raise tc if not gated.
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, "reset_hold");

        // Release between edges, count up through the wrap.
        #2 reset = 1'b1;
        for (int i = 0; i < 12; i++) tick(0, 0, 1, 1, "count_up");

        // Load 3 and count down across zero.
        tick(1, 3, 1, 0, "load3");
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, "count_down");

        // Load beats enable; out-of-range values are clamped.
        tick(1, 7, 1, 1, "load_prio");
        tick(1, 13, 1, 1, "load_clamp");
        tick(1, 15, 0, 0, "load_clamp15");

        // Hold at 5, then alternate direction every edge.
        tick(1, 5, 0, 0, "load5");
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, "hold");
        for (int i = 0; i < 4; i++) tick(0, 0, 1, (i % 2) == 0, "dir_toggle");

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1), "random");

        // Asynchronous reset mid-cycle with a load pending.
        tick(1, 6, 0, 1, "pre_reset_load");
        load     = 1'b1;
        load_val = W'(2);
        #3 reset = 1'b0;
        #1;
        check("async_reset s", 32'(s), 32'(0));
        check("async_reset wrap", 32'(wrap), 32'(0));
        check("async_reset tc", 32'(tc), 32'(0));
        m_s    = 0;
        m_wrap = 0;
        tick(1, 2, 1, 1, "reset_low_edge");
        #2 reset = 1'b1;
        tick(0, 0, 1, 1, "after_reset");

        // Two-digit cascade: units tc enables tens.
        en         = 1'b0;
        load       = 1'b0;
        cu         = 0;
        ct         = 0;
        tens_wraps = 0;
        check("casc_init units", 32'(units_s), 32'(0));
        check("casc_init tens", 32'(tens_s), 32'(0));
        casc_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            tc_u = (cu == MOD - 1) ? 1 : 0;
            check("casc units_tc", 32'(units_tc), 32'(tc_u));
            @(posedge pulse);
            #1;
            wu = step_wraps(cu, 1);
            wt = tc_u ? step_wraps(ct, 1) : 0;
            cu = step_val(cu, 1);
            if (tc_u) ct = step_val(ct, 1);
            tens_wraps += int'(tens_wrap);
            check("casc units", 32'(units_s), 32'(cu));
            check("casc tens", 32'(tens_s), 32'(ct));
            check("casc units_wrap", 32'(units_wrap), 32'(wu));
            check("casc tens_wrap", 32'(tens_wrap), 32'(wt));
        end
`ifdef UPDOWN_COUNTER_SATURATE_EN
        check("casc tens_wrap_count", 32'(tens_wraps), 32'(0));
`else
        check("casc tens_wrap_count", 32'(tens_wraps), 32'(1));
`endif
        casc_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
